// File: rtl/lab2_proc_iter_muldiv_unit.sv
// Iterative MUL/DIV/DIVU/REM/REMU unit: shift-add multiply, restoring divide, val/rdy handshakes.
// Optional LAB2_PROC_MULDIV_EARLY_EXIT_EN: MUL stops once the multiplier drains; op_b==0 skips CALC.
module lab2_proc_iter_muldiv_unit #(
    parameter int NITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [2:0]  req_fn,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_msg,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [2:0]  r_fn;
    logic [31:0] r_mcand, r_mplier, r_prod, r_divisor;
    logic [63:0] r_rem;
    logic        r_neg_q, r_neg_r;
    logic        r_resp_val, r_busy;
    logic [31:0] r_resp_msg;

    logic        w_signed, w_b_zero, w_last, w_exit;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] w_prod_nxt, w_mplier_nxt, w_quo, w_rmd, w_result;
    logic [32:0] w_sub;
    logic [63:0] w_rem_nxt;

    assign w_signed = (req_fn == FN_DIV) || (req_fn == FN_REM);
    assign w_b_zero = (req_op_b == 32'd0);
    assign w_a_mag  = (w_signed && req_op_a[31]) ? -req_op_a : req_op_a;
    assign w_b_mag  = (w_signed && req_op_b[31]) ? -req_op_b : req_op_b;

    assign w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : 32'd0);
    assign w_mplier_nxt = r_mplier >> 1;

    // 33-bit trial subtract: the bit shifted out of the remainder's top must take part in the compare
    assign w_sub     = r_rem[63:31] - {1'b0, r_divisor};
    assign w_rem_nxt = w_sub[32] ? {r_rem[62:0], 1'b0} : {w_sub[31:0], r_rem[30:0], 1'b1};
    assign w_quo     = w_rem_nxt[31:0];
    assign w_rmd     = w_rem_nxt[63:32];

    always_comb begin
        w_result = 32'd0;
        case (r_fn)
            FN_MUL:          w_result = w_prod_nxt;
            FN_DIV, FN_DIVU: w_result = r_neg_q ? -w_quo : w_quo;
            FN_REM, FN_REMU: w_result = r_neg_r ? -w_rmd : w_rmd;
            default:         w_result = 32'd0;
        endcase
    end

    assign w_last = (r_cnt == 6'(NITERS - 1));
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
    assign w_exit = w_last || ((r_fn == FN_MUL) && (w_mplier_nxt == 32'd0));
`else
    assign w_exit = w_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 6'd0;
            r_fn       <= 3'd0;
            r_mcand    <= 32'd0;
            r_mplier   <= 32'd0;
            r_prod     <= 32'd0;
            r_divisor  <= 32'd0;
            r_rem      <= 64'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_resp_val <= 1'b0;
            r_resp_msg <= 32'd0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_val) begin
                    r_fn      <= req_fn;
                    r_mcand   <= req_op_a;
                    r_mplier  <= req_op_b;
                    r_prod    <= 32'd0;
                    r_divisor <= w_b_mag;
                    r_rem     <= {32'd0, w_a_mag};
                    // zero divisor yields all-ones quotient; keep it unsigned so DIV x/0 stays 0xFFFFFFFF
                    r_neg_q   <= (req_fn == FN_DIV) && (req_op_a[31] ^ req_op_b[31]) && !w_b_zero;
                    r_neg_r   <= (req_fn == FN_REM) && req_op_a[31];
                    r_cnt     <= 6'd0;
                    r_busy    <= 1'b1;
                    r_state   <= CALC;
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
                    if (w_b_zero && (req_fn <= FN_REMU)) begin
                        r_state    <= DONE;
                        r_resp_val <= 1'b1;
                        case (req_fn)
                            FN_MUL:          r_resp_msg <= 32'd0;
                            FN_DIV, FN_DIVU: r_resp_msg <= 32'hFFFF_FFFF;
                            default:         r_resp_msg <= req_op_a;
                        endcase
                    end
`endif
                end
                CALC: begin
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_rem    <= w_rem_nxt;
                    r_cnt    <= r_cnt + 6'd1;
                    if (w_exit) begin
                        r_state    <= DONE;
                        r_resp_val <= 1'b1;
                        r_resp_msg <= w_result;
                    end
                end
                DONE: if (resp_rdy) begin
                    r_state    <= IDLE;
                    r_resp_val <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_rdy  = (r_state == IDLE) && !reset;
    assign resp_val = r_resp_val;
    assign resp_msg = r_resp_msg;
    assign busy     = r_busy;
endmodule

// File: tb/tb_lab2_proc_iter_muldiv_unit.sv
// Bench for lab2_proc_iter_muldiv_unit (default build): arithmetic reference model plus per-cycle compare.
module tb_lab2_proc_iter_muldiv_unit;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset, req_val, resp_rdy;
    logic [2:0]  req_fn;
    logic [31:0] req_op_a, req_op_b;
    logic        req_rdy, resp_val, busy;
    logic [31:0] resp_msg;

    always #5 clk = ~clk;

    lab2_proc_iter_muldiv_unit dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            3'd0: return p[31:0];
            3'd1: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            3'd4: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Timing model: an accepted op answers LAT cycles later and holds until resp_rdy.
    bit          started = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    logic [31:0] m_exp   = 32'd0;

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) m_busy = 1'b0;
        else if (m_busy && m_age >= LAT - 1) begin
            if (resp_rdy) m_busy = 1'b0;
        end
        else if (m_busy) m_age++;
        else if (req_val) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_exp  = ref_res(req_fn, req_op_a, req_op_b);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_rdy",  32'(req_rdy),  32'(!m_busy && !reset));
            chk("busy",     32'(busy),     32'(m_busy));
            chk("resp_val", 32'(resp_val), 32'(m_busy && m_age >= LAT - 1));
            if (m_busy && m_age >= LAT - 1) chk("resp_msg", resp_msg, m_exp);
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return $urandom % 20;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output int lat);
        int k;
        k = 0;
        while (!req_rdy && k < 100) begin nstep(); k++; end
        chk("req_rdy_wait", 32'(req_rdy), 32'd1);
        req_val = 1'b1; req_fn = fn; req_op_a = a; req_op_b = b;
        @(posedge clk);
        #1;
        lat = 0;
        while (!resp_val && lat < 100) begin
            // request side and resp_rdy must be ignored while the op is in flight
            req_val  = 1'($urandom);
            req_fn   = 3'($urandom);
            req_op_a = $urandom;
            req_op_b = $urandom;
            resp_rdy = (lat < 20) ? 1'($urandom) : 1'b0;
            nstep();
            lat++;
        end
        chk("resp_wait", 32'(resp_val), 32'd1);
        res = resp_msg;
        repeat (hold) nstep();
        resp_rdy = 1'b1;
        req_val  = 1'b0;
        nstep();
        resp_rdy = 1'b0;
    endtask

    logic [31:0] res;
    int          lat;

    initial begin
        reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0;
        req_fn = 3'd0; req_op_a = 32'd0; req_op_b = 32'd0;
        repeat (3) nstep();
        chk("rst_resp_msg", resp_msg, 32'd0);
        chk("rst_resp_val", 32'(resp_val), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        reset = 1'b0;
        nstep();

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, res, lat);
        chk("mul_7x-3", res, 32'hFFFF_FFEB);
        chk("mul_latency", 32'(lat), 32'd33);
        do_op(3'd1, 32'hFFFF_FFF9, 32'd2, 0, res, lat);   chk("div_-7/2", res, 32'hFFFF_FFFD);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, res, lat);   chk("rem_-7/2", res, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd2, 0, res, lat);   chk("divu_max", res, 32'h7FFF_FFFF);
        do_op(3'd4, 32'd13, 32'd4, 0, res, lat);          chk("remu_13/4", res, 32'd1);
        do_op(3'd1, 32'd5, 32'd0, 0, res, lat);           chk("div_by0", res, 32'hFFFF_FFFF);
        chk("div_by0_latency", 32'(lat), 32'd33);
        do_op(3'd4, 32'd5, 32'd0, 0, res, lat);           chk("remu_by0", res, 32'd5);
        do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat); chk("div_ovf", res, 32'h8000_0000);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat); chk("rem_ovf", res, 32'd0);
        do_op(3'd6, 32'd9, 32'd3, 0, res, lat);           chk("illegal_fn", res, 32'd0);
        do_op(3'd1, 32'd100, 32'd7, 10, res, lat);        chk("div_hold", res, 32'd14);
        do_op(3'd0, 32'd6, 32'd7, 0, res, lat);           chk("mul_b2b", res, 32'd42);

        // abort mid-calculation: no response may surface afterwards
        while (!req_rdy) nstep();
        req_val = 1'b1; req_fn = 3'd0; req_op_a = 32'd3; req_op_b = 32'd5;
        nstep();
        req_val = 1'b0;
        repeat (10) nstep();
        reset = 1'b1;
        nstep();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_val", 32'(resp_val), 32'd0);
        repeat (40) nstep();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  fn;
            logic [31:0] a, b;
            fn = ($urandom % 8 < 6) ? 3'($urandom % 5) : 3'($urandom);
            a  = rnd_op();
            b  = rnd_op();
            do_op(fn, a, b, int'($urandom % 4), res, lat);
        end

        repeat (3) nstep();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
